// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: 8N1 UART receiver with a small first-word-fall-through FIFO.
// The rxd line is synchronised, each bit is sampled at its centre, and completed
// bytes are queued for the CPU side. The CPU side drains the queue with rd_req/data_valid.
module uart_rx_fifo #(
    parameter int unsigned CLKS_PER_BIT = 434,
    parameter int unsigned FIFO_AW      = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               rxd,
    input  logic               rd_req,
    output logic [7:0]         rd_data,
    output logic               data_valid,
    output logic [FIFO_AW:0]   fifo_count,
    output logic               frame_err,
    output logic               overrun,
    input  logic               err_clr
);

    localparam int unsigned DEPTH = 1 << FIFO_AW;
    localparam int unsigned CW    = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_WAIT} state_t;

    state_t            r_state, w_state_nxt;
    logic [1:0]        r_sync;
    logic              w_rxs;
    logic [CW-1:0]     r_cnt, w_cnt_nxt;
    logic [2:0]        r_idx, w_idx_nxt;
    logic [7:0]        r_shift, w_shift_nxt;
    logic              w_push, w_frame_set;

    logic [7:0]        r_mem [DEPTH];
    logic [FIFO_AW:0]  r_wptr, r_rptr, w_wptr_nxt, w_rptr_nxt, w_count;
    logic              r_valid;
    logic [7:0]        r_rdata, w_head;
    logic              w_full, w_pop, w_wr, w_ovr_set;
    logic              r_frame_err, r_overrun;

    assign w_rxs = r_sync[1];

    // Two-flop synchroniser for the asynchronous rxd line (idle high)
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_sync <= '1;
        else       r_sync <= {r_sync[0], rxd};
    end

    // Receiver state, bit counter, bit index and shift register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_shift <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_idx   <= w_idx_nxt;
            r_shift <= w_shift_nxt;
        end
    end

    // Deframing: half-bit into START, then full-bit steps land on bit centres
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt + 1'b1;
        w_idx_nxt   = r_idx;
        w_shift_nxt = r_shift;
        w_push      = 1'b0;
        w_frame_set = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_cnt_nxt = '0;
                if (!w_rxs) w_state_nxt = S_START;
            end
            S_START: begin
                if (r_cnt == CNT_HALF) begin
                    w_cnt_nxt   = '0;
                    w_idx_nxt   = '0;
                    w_state_nxt = w_rxs ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (r_cnt == CNT_LAST) begin
                    w_cnt_nxt          = '0;
                    w_shift_nxt[r_idx] = w_rxs;
                    w_idx_nxt          = r_idx + 1'b1;
                    if (r_idx == 3'd7) w_state_nxt = S_STOP;
                end
            end
            S_STOP: begin
                if (r_cnt == CNT_LAST) begin
                    w_cnt_nxt = '0;
                    if (w_rxs) begin
                        w_push      = 1'b1;
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_frame_set = 1'b1;
                        w_state_nxt = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                w_cnt_nxt = '0;
                if (w_rxs) w_state_nxt = S_IDLE;
            end
            default: begin
                w_cnt_nxt   = '0;
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // FIFO control: a pop in the same cycle frees the slot for a push into a full FIFO
    always_comb begin
        w_count    = r_wptr - r_rptr;
        w_full     = (w_count == (FIFO_AW + 1)'(DEPTH));
        w_pop      = rd_req && r_valid;
        w_wr       = w_push && (!w_full || w_pop);
        w_ovr_set  = w_push && w_full && !w_pop;
        w_wptr_nxt = r_wptr + {{FIFO_AW{1'b0}}, w_wr};
        w_rptr_nxt = r_rptr + {{FIFO_AW{1'b0}}, w_pop};
        // The new head comes straight from the shift register when it is being written this cycle
        if (w_wr && (r_wptr[FIFO_AW-1:0] == w_rptr_nxt[FIFO_AW-1:0]))
            w_head = r_shift;
        else
            w_head = r_mem[w_rptr_nxt[FIFO_AW-1:0]];
    end

    // FIFO storage write
    always_ff @(posedge clk) begin
        if (w_wr) r_mem[r_wptr[FIFO_AW-1:0]] <= r_shift;
    end

    // FIFO pointers and registered head/valid outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_valid <= 1'b0;
            r_rdata <= '0;
        end else begin
            r_wptr  <= w_wptr_nxt;
            r_rptr  <= w_rptr_nxt;
            r_valid <= (w_wptr_nxt != w_rptr_nxt);
            if (w_wptr_nxt != w_rptr_nxt) r_rdata <= w_head;
        end
    end

    // Sticky error flags; a new error wins over a simultaneous clear
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            if (w_frame_set)  r_frame_err <= 1'b1;
            else if (err_clr) r_frame_err <= 1'b0;
            if (w_ovr_set)    r_overrun   <= 1'b1;
            else if (err_clr) r_overrun   <= 1'b0;
        end
    end

    assign rd_data    = r_rdata;
    assign data_valid = r_valid;
    assign fifo_count = w_count;
    assign frame_err  = r_frame_err;
    assign overrun    = r_overrun;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo at 16 clocks per bit and a 4-entry FIFO.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_uart_rx_fifo;

    logic       clk;
    logic       reset;
    logic       rxd;
    logic       rd_req;
    logic [7:0] rd_data;
    logic       data_valid;
    logic [2:0] fifo_count;
    logic       frame_err;
    logic       overrun;
    logic       err_clr;

    int unsigned n_vec;
    int unsigned n_err;

    uart_rx_fifo #(
        .CLKS_PER_BIT (16),
        .FIFO_AW      (2)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .rxd        (rxd),
        .rd_req     (rd_req),
        .rd_data    (rd_data),
        .data_valid (data_valid),
        .fifo_count (fifo_count),
        .frame_err  (frame_err),
        .overrun    (overrun),
        .err_clr    (err_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_vec++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic cycles(input int unsigned n);
        repeat (n) @(negedge clk);
    endtask

    // Start bit plus eight data bits, LSB first; returns at the start of the stop bit
    task automatic send_head(input logic [7:0] b);
        rxd = 1'b0;
        cycles(16);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            cycles(16);
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_v);
        send_head(b);
        rxd = stop_v;
        cycles(16);
        rxd = 1'b1;
    endtask

    task automatic pop();
        rd_req = 1'b1;
        cycles(1);
        rd_req = 1'b0;
    endtask

    task automatic pulse_clr();
        err_clr = 1'b1;
        cycles(1);
        err_clr = 1'b0;
    endtask

    initial begin
        n_vec   = 0;
        n_err   = 0;
        reset   = 1'b1;
        rxd     = 1'b1;
        rd_req  = 1'b0;
        err_clr = 1'b0;
        cycles(3);
        reset = 1'b0;
        cycles(2);

        // Reset state
        chk("rst_valid", 32'(data_valid), 32'd0);
        chk("rst_count", 32'(fifo_count), 32'd0);
        chk("rst_data",  32'(rd_data),    32'h00);
        chk("rst_ferr",  32'(frame_err),  32'd0);
        chk("rst_ovr",   32'(overrun),    32'd0);

        // 0xA5: stop sample lands on the 10th edge of the stop bit
        send_head(8'hA5);
        rxd = 1'b1;
        cycles(10);
        chk("a5_pre_valid", 32'(data_valid), 32'd0);
        cycles(1);
        chk("a5_valid", 32'(data_valid), 32'd1);
        chk("a5_data",  32'(rd_data),    32'hA5);
        chk("a5_count", 32'(fifo_count), 32'd1);
        cycles(5);
        pop();
        chk("a5_pop_valid", 32'(data_valid), 32'd0);
        chk("a5_pop_count", 32'(fifo_count), 32'd0);

        // Pop while empty has no effect
        pop();
        chk("empty_pop_count", 32'(fifo_count), 32'd0);

        // Push and pop together while empty: push only
        send_head(8'h5A);
        rxd = 1'b1;
        cycles(10);
        rd_req = 1'b1;
        cycles(1);
        rd_req = 1'b0;
        chk("pe_count", 32'(fifo_count), 32'd1);
        chk("pe_data",  32'(rd_data),    32'h5A);
        cycles(5);
        pop();

        // Five bytes back to back with no reads: fifth overruns
        for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b1);
        chk("ovr_count", 32'(fifo_count), 32'd4);
        chk("ovr_flag",  32'(overrun),    32'd1);
        chk("ovr_ferr",  32'(frame_err),  32'd0);
        chk("ovr_rd0", 32'(rd_data), 32'h01); pop();
        chk("ovr_rd1", 32'(rd_data), 32'h02); pop();
        chk("ovr_rd2", 32'(rd_data), 32'h03); pop();
        chk("ovr_rd3", 32'(rd_data), 32'h04); pop();
        chk("ovr_drained", 32'(data_valid), 32'd0);
        pulse_clr();
        chk("ovr_clr", 32'(overrun), 32'd0);

        // Short low glitch is rejected
        rxd = 1'b0;
        cycles(5);
        rxd = 1'b1;
        cycles(30);
        chk("glitch_count", 32'(fifo_count), 32'd0);
        chk("glitch_ferr",  32'(frame_err),  32'd0);
        send_frame(8'hC3, 1'b1);
        chk("glitch_next", 32'(rd_data), 32'hC3);
        pop();

        // Framing error on 0x3C, then 0x7E is still received
        send_frame(8'h3C, 1'b0);
        chk("fe_flag",  32'(frame_err),  32'd1);
        chk("fe_count", 32'(fifo_count), 32'd0);
        cycles(4);
        send_frame(8'h7E, 1'b1);
        chk("fe_next_data",  32'(rd_data),    32'h7E);
        chk("fe_next_count", 32'(fifo_count), 32'd1);
        chk("fe_sticky",     32'(frame_err),  32'd1);
        pop();
        pulse_clr();
        chk("fe_clr", 32'(frame_err), 32'd0);

        // New framing error in the same cycle as err_clr: set wins
        send_head(8'h00);
        rxd = 1'b0;
        cycles(10);
        err_clr = 1'b1;
        cycles(1);
        err_clr = 1'b0;
        chk("set_wins", 32'(frame_err), 32'd1);
        rxd = 1'b1;
        cycles(8);
        pulse_clr();

        // Full FIFO with a pop on the stop-sample edge of a fifth byte
        send_frame(8'h11, 1'b1);
        send_frame(8'h22, 1'b1);
        send_frame(8'h33, 1'b1);
        send_frame(8'h44, 1'b1);
        chk("full_count", 32'(fifo_count), 32'd4);
        send_head(8'h55);
        rxd = 1'b1;
        cycles(10);
        rd_req = 1'b1;
        cycles(1);
        rd_req = 1'b0;
        chk("pp_count", 32'(fifo_count), 32'd4);
        chk("pp_ovr",   32'(overrun),    32'd0);
        chk("pp_head",  32'(rd_data),    32'h22);
        cycles(5);
        pop();
        chk("pp_rd1", 32'(rd_data), 32'h33); pop();
        chk("pp_rd2", 32'(rd_data), 32'h44); pop();
        chk("pp_rd3", 32'(rd_data), 32'h55); pop();
        chk("pp_empty", 32'(fifo_count), 32'd0);

        // Reset in the middle of 0xFF data, then 0x42
        rxd = 1'b0;
        cycles(16);
        rxd = 1'b1;
        cycles(40);
        reset = 1'b1;
        cycles(2);
        reset = 1'b0;
        cycles(100);
        chk("mid_rst_valid", 32'(data_valid), 32'd0);
        send_frame(8'h42, 1'b1);
        chk("mid_rst_data",  32'(rd_data),    32'h42);
        chk("mid_rst_count", 32'(fifo_count), 32'd1);
        chk("mid_rst_ferr",  32'(frame_err),  32'd0);
        chk("mid_rst_ovr",   32'(overrun),    32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
